// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-requester round-robin arbiter in front of a shared FP unit
// Latches the winner's operands, runs one FP operation with a timeout, pulses the winner's done.
module fpu_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic [1:0]  sp_op,
    output logic [31:0] sp_a,
    output logic [31:0] sp_b,
    output logic        sp_go,
    input  logic        sp_done,
    input  logic [31:0] sp_d
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        winner_q;
    logic        last_q;
    logic        done0_q;
    logic        done1_q;
    logic        sp_go_q;
    logic        err_q;
    logic [31:0] result_q;
    logic [1:0]  sp_op_q;
    logic [31:0] sp_a_q;
    logic [31:0] sp_b_q;
    logic        pick1;

    // Requester 1 wins when alone, or when both ask and requester 0 was served last.
    assign pick1 = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            sp_go_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= 32'd0;
            sp_op_q  <= 2'd0;
            sp_a_q   <= 32'd0;
            sp_b_q   <= 32'd0;
        end else begin
            sp_go_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        winner_q <= pick1;
                        sp_op_q  <= pick1 ? op1 : op0;
                        sp_a_q   <= pick1 ? a1 : a0;
                        sp_b_q   <= pick1 ? b1 : b0;
                        sp_go_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= 8'd0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A completion in the final allowed cycle still beats the abort.
                    if (sp_done || cnt_q >= CNT_LAST) begin
                        result_q <= sp_done ? sp_d : QNAN;
                        err_q    <= ~sp_done;
                        done0_q  <= ~winner_q;
                        done1_q  <= winner_q;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    last_q  <= winner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);
    assign sp_op  = sp_op_q;
    assign sp_a   = sp_a_q;
    assign sp_b   = sp_b_q;
    assign sp_go  = sp_go_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - scoreboard bench for fpu_arbiter with a stub FP unit
module tb_fpu_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        done0, done1, err, busy, sp_go;
    logic [31:0] result, sp_a, sp_b;
    logic [1:0]  sp_op;
    logic        sp_done = 1'b0;
    logic [31:0] sp_d = '0;

    fpu_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
        .sp_op(sp_op), .sp_a(sp_a), .sp_b(sp_b), .sp_go(sp_go),
        .sp_done(sp_done), .sp_d(sp_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int lat_force = 0;
    int go_cnt = 0;
    int done_cnt[2] = '{0, 0};
    int done_cyc[2] = '{0, 0};
    int order_q[$];
    logic [32:0] expq0[$];
    logic [32:0] expq1[$];
    logic [32:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub FP unit: answers n cycles after sp_go, with n taken from the operands.
    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
        logic [1:0] x;
        x = a[1:0] ^ b[1:0];
        return (lat_force != 0) ? lat_force : 1 + int'(x);
    endfunction

    function automatic logic [31:0] val_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd2 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    // Reference: the unit's answer arrives in time only if WAIT has not used up TO cycles.
    function automatic logic [32:0] expect_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (lat_of(a, b) + 1 > TO) return {1'b1, 32'h7FC0_0000};
        return {1'b0, val_of(op, a, b)};
    endfunction

    initial begin
        int cd;
        logic [31:0] pend;
        cd = 0;
        pend = '0;
        forever begin
            @(posedge clk);
            #1;
            sp_done = 1'b0;
            sp_d = $urandom;
            if (sp_go) begin
                go_cnt++;
                cd = lat_of(sp_a, sp_b) + 1;
                pend = val_of(sp_op, sp_a, sp_b);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    sp_done = 1'b1;
                    sp_d = pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done0 || done1) chk("done_onehot", {63'd0, done0 & done1}, 64'd0);
        if (done0) begin
            done_cnt[0]++;
            done_cyc[0] = cyc;
            order_q.push_back(0);
            if (expq0.size() == 0) chk("unexpected_done0", 64'd1, 64'd0);
            else begin
                mon_e = expq0.pop_front();
                chk("resp0", {31'd0, err, result}, {31'd0, mon_e});
            end
        end
        if (done1) begin
            done_cnt[1]++;
            done_cyc[1] = cyc;
            order_q.push_back(1);
            if (expq1.size() == 0) chk("unexpected_done1", 64'd1, 64'd0);
            else begin
                mon_e = expq1.pop_front();
                chk("resp1", {31'd0, err, result}, {31'd0, mon_e});
            end
        end
    end

    task automatic run_req(input int k, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int lat);
        int start;
        int c0;
        int n;
        start = done_cnt[k];
        n = 0;
        if (k == 0) begin
            expq0.push_back(expect_of(op, a, b));
            op0 = op; a0 = a; b0 = b; req0 = 1'b1;
        end else begin
            expq1.push_back(expect_of(op, a, b));
            op1 = op; a1 = a; b1 = b; req1 = 1'b1;
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        while (done_cnt[k] == start && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_count", 64'(done_cnt[k] - start), 64'd1);
        lat = done_cyc[k] - c0 + 1;
        if (k == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic rand_stream(input int k);
        int lat;
        for (int i = 0; i < 25; i++) begin
            run_req(k, 2'($urandom), $urandom, $urandom, lat);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb, g0, d0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {59'd0, busy, sp_go, done0, done1, err}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_sp", {sp_op, sp_a, sp_b}, 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        lat_force = 2;
        order_q.delete();
        fork
            run_req(0, 2'd0, 32'h1111_0000, 32'h2222_0000, la);
            run_req(1, 2'd1, 32'h3333_0000, 32'h4444_0000, lb);
        join
        repeat (2) @(posedge clk);
        #1;
        fork
            run_req(0, 2'd2, 32'h5555_0000, 32'h6666_0000, la);
            run_req(1, 2'd3, 32'h7777_0000, 32'h8888_0000, lb);
        join
        chk("rr_len", 64'(order_q.size()), 64'd4);
        if (order_q.size() == 4)
            chk("rr_order", {order_q[0][3:0], order_q[1][3:0], order_q[2][3:0], order_q[3][3:0]}, 64'h0101);

        lat_force = 3;
        g0 = go_cnt;
        run_req(0, 2'd2, 32'h3F80_0000, 32'h4000_0000, la);
        chk("lat_single", 64'(la), 64'd6);
        chk("go_once", 64'(go_cnt - g0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("result_hold", {31'd0, err, result}, {31'd0, 1'b0, 32'h4040_0000});

        lat_force = 50;
        run_req(1, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678, la);
        chk("lat_timeout", 64'(la), 64'(TO + 2));
        @(posedge clk);
        #1;
        lat_force = 4;
        run_req(0, 2'd1, 32'hAAAA_0001, 32'h5555_0002, la);
        chk("lat_boundary_abort", 64'(la), 64'(TO + 2));
        @(posedge clk);
        #1;
        lat_force = 1;
        run_req(0, 2'd0, 32'h0BAD_F00D, 32'hC0FF_EE00, la);
        chk("lat_after_timeout", 64'(la), 64'd4);
        @(posedge clk);
        #1;

        lat_force = 3;
        fork
            run_req(1, 2'd1, 32'h0102_0304, 32'h0506_0708, la);
            begin
                repeat (3) @(posedge clk);
                #1;
                a1 = ~a1;
                b1 = ~b1;
                @(posedge clk);
                #1;
                chk("sp_a_stable", {32'd0, sp_a}, {32'd0, 32'h0102_0304});
                chk("sp_b_stable", {32'd0, sp_b}, {32'd0, 32'h0506_0708});
            end
        join
        @(posedge clk);
        #1;

        d0 = done_cnt[0] + done_cnt[1];
        op0 = 2'd2; a0 = 32'h4100_0000; b0 = 32'h4200_0000; req0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        req0 = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_sp", {sp_op, sp_a, sp_b}, 64'd0);
        @(negedge clk) reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_done", 64'(done_cnt[0] + done_cnt[1] - d0), 64'd0);
        chk("rst_idle_after_stray", {62'd0, busy, err}, 64'd0);
        chk("rst_result_cleared", {32'd0, result}, 64'd0);

        lat_force = 0;
        fork
            rand_stream(0);
            rand_stream(1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 64'(expq0.size() + expq1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum cycles spent in WAIT before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low: 0 forces the reset state immediately.
REQ-004 req0, req1  input  1 each  requester k asks for one FP operation; held high until its done pulse.
REQ-005 op0, op1  input  2 each  operation code: 0 MULT, 1 DIV, 2 ADD, 3 SUB; stable while reqk is high.
REQ-006 a0, b0, a1, b1  input  32 each  IEEE-754 single operands; stable while reqk is high.
REQ-007 done0, done1  output  1 each  one-cycle pulse; result and err are valid for requester k in that cycle.
REQ-008 result  output  32  completed result, shared by both requesters.
REQ-009 err  output  1  qualifies done pulse: 1 = timeout abort.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 sp_op  output  2  operation code to the FP unit.
REQ-012 sp_a, sp_b  output  32 each  operands to the FP unit, driven from internal registers.
REQ-013 sp_go  output  1  start pulse to the FP unit.
REQ-014 sp_done  input  1  FP unit completion.
REQ-015 sp_d  input  32  FP unit result.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE, no request: remain in IDLE.
REQ-018 IDLE, any reqk high: select one winner, latch its op/a/b into sp_op/sp_a/sp_b, record the winner index, go to ISSUE.
REQ-019 Arbitration is round-robin: if both requests are high, grant the requester not granted last; after reset, requester 0 has priority.
REQ-020 ISSUE: sp_go=1 for exactly this one cycle; clear timeout counter; go to WAIT.
REQ-021 WAIT: sp_go=0.
REQ-022 WAIT, sp_done=1: capture sp_d into result, set err=0, go to RESP.
REQ-023 WAIT, counter reaches TIMEOUT with sp_done still 0: set result=32'h7FC00000 and err=1, go to RESP.
REQ-024 WAIT, otherwise: increment the 8-bit counter; it does not wrap, because it stops at TIMEOUT.
REQ-025 RESP: assert done pulse of the recorded winner only; update last-granted to the winner; go to IDLE.
REQ-026 sp_done is ignored outside WAIT.
REQ-027 A request dropped before its done pulse does not abort the operation; the done pulse is still issued.
REQ-028 Latency, when the FP unit answers n cycles after sp_go: req sampled in IDLE at edge 0 -> done at cycle n+3.
REQ-029 Minimum issue-to-issue spacing is 4 cycles.
REQ-030 A requester deasserts req on the edge that ends its done pulse, so IDLE never re-grants a completed request.
REQ-031 sp_op/sp_a/sp_b hold stable from ISSUE through RESP.
REQ-032 result/err hold their value until the next capture.
REQ-033 done0 and done1 are never high in the same cycle.
REQ-034 No combinational path exists from any input to any output.

Reset
REQ-035 reset=0 at any time, including mid-WAIT:
- state=IDLE
- sp_go=0, done0=done1=0, busy=0
- result=0, err=0
- sp_op=0, sp_a=0, sp_b=0
- counter=0
- last-granted = requester 1, so requester 0 wins first
REQ-036 The in-flight operation is discarded with no done pulse; a later sp_done is ignored.
REQ-037 Operation resumes on the first rising clk edge after reset returns to 1.

Verification
REQ-038 Single request: req0=1, op0=2, a0=3F800000, b0=40000000, FP done after 5 cycles -> sp_go pulse once; done0 at cycle 8; result=40400000, err=0.
REQ-039 Simultaneous requests, from reset: req0=req1=1 -> requester 0 served first, then requester 1. Repeat with both high again -> order 0,1,0,1; never two done in one cycle.
REQ-040 Timeout: TIMEOUT=4, sp_done held 0 -> done pulse after 4 WAIT cycles with result=7FC00000, err=1; arbiter returns to IDLE and serves the next request normally.
REQ-041 Reset mid-operation: reset=0 during WAIT, then sp_done=1 after release -> no done pulse, busy=0, result=0.
REQ-042 Stray and stable-operand checks:
- sp_done=1 while in IDLE -> no state change.
- Operands changed on req1 during WAIT -> sp_a/sp_b unchanged.
